// File: rtl/instr_sequencer_if.sv
// Instruction-memory, decoder, ALU-flag and data-memory handshake bundle
// between the sequencer (master) and the datapath around it (slave).
interface instr_sequencer_if #(
    parameter int PC_WIDTH  = 10,
    parameter int IMM_WIDTH = 8
);
    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic                 imem_valid;
    logic                 ir_load;
    logic                 dec_jump;
    logic                 dec_branch;
    logic                 alu_zero;
    logic [IMM_WIDTH-1:0] dec_imm;
    logic                 dec_reg_write;
    logic                 dec_mem_read;
    logic                 dec_mem_write;
    logic                 dec_done;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_ack;
    logic                 reg_we;

    modport master (
        output imem_req, imem_addr, ir_load, mem_req, mem_we, reg_we,
        input  imem_valid, dec_jump, dec_branch, alu_zero, dec_imm,
               dec_reg_write, dec_mem_read, dec_mem_write, dec_done, mem_ack
    );

    modport slave (
        input  imem_req, imem_addr, ir_load, mem_req, mem_we, reg_we,
        output imem_valid, dec_jump, dec_branch, alu_zero, dec_imm,
               dec_reg_write, dec_mem_read, dec_mem_write, dec_done, mem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute/memory control FSM for the 9-bit-instruction datapath:
// owns the PC, the retired-instruction counter and the register-write qualification.
module instr_sequencer #(
    parameter int PC_WIDTH  = 10,
    parameter int IMM_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    instr_sequencer_if.master    bus,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [PC_WIDTH-1:0]  pc, pc_nxt, seq_pc, imm_ext;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ir_load, reg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_count <= cnt_nxt;
        end
    end

    // Immediate is two's complement; all PC arithmetic wraps modulo 2^PC_WIDTH.
    assign imm_ext = PC_WIDTH'($signed(bus.dec_imm));

    always_comb begin
        if (bus.dec_jump)
            seq_pc = pc + imm_ext;
        else if (bus.dec_branch && bus.alu_zero)
            seq_pc = pc + PC_WIDTH'(2);
        else
            seq_pc = pc + PC_WIDTH'(1);
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = instr_count;
        ir_load   = 1'b0;
        reg_we    = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_nxt    = start_pc;
                    cnt_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (bus.imem_valid) begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                // Halt retires in place; memory ops retire only once MEM completes.
                if (bus.dec_done) begin
                    cnt_nxt   = instr_count + CNT_WIDTH'(1);
                    state_nxt = HALT;
                end else if (bus.dec_mem_read || bus.dec_mem_write) begin
                    state_nxt = MEM;
                end else begin
                    reg_we    = bus.dec_reg_write;
                    cnt_nxt   = instr_count + CNT_WIDTH'(1);
                    pc_nxt    = seq_pc;
                    state_nxt = FETCH;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    reg_we    = bus.dec_mem_read;
                    pc_nxt    = pc + PC_WIDTH'(1);
                    cnt_nxt   = instr_count + CNT_WIDTH'(1);
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.imem_req  = (state == FETCH);
    assign bus.imem_addr = pc;
    assign bus.ir_load   = ir_load;
    assign bus.mem_req   = (state == MEM);
    assign bus.mem_we    = (state == MEM) && bus.dec_mem_write;
    assign bus.reg_we    = reg_we;
    assign busy          = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign halted        = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a small program ROM plus a latched IR
// stand in for instruction memory and the decoder.
module tb_instr_sequencer;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       done;
        logic [7:0] imm;
    } ins_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    ins_t prog [1024];
    ins_t ir;

    int n_cmp;
    int n_fail;

    instr_sequencer_if #(.PC_WIDTH(10), .IMM_WIDTH(8)) bus ();

    instr_sequencer #(.PC_WIDTH(10), .IMM_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ir_load) ir <= prog[bus.imem_addr];
    end

    assign bus.dec_jump      = ir.jump;
    assign bus.dec_branch    = ir.branch;
    assign bus.dec_imm       = ir.imm;
    assign bus.dec_reg_write = ir.rw;
    assign bus.dec_mem_read  = ir.mr;
    assign bus.dec_mem_write = ir.mw;
    assign bus.dec_done      = ir.done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        start_pc       = '0;
        bus.imem_valid = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.alu_zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) prog[i] = '0;
    endtask

    task automatic do_start(input logic [9:0] pc);
        start_pc = pc;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 000", bus.imem_addr); end
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem: req=%b we=%b want 0/0", bus.mem_req, bus.mem_we); end
        n_cmp++; if (bus.ir_load !== 1'b0 || bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: ir_load=%b reg_we=%b want 0/0", bus.ir_load, bus.reg_we); end
        n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_status: busy=%b halted=%b want 0/0", busy, halted); end
        n_cmp++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    endtask

    task automatic test_program();
        logic [9:0] fa [4];
        int nf;
        int nrw;
        nf  = 0;
        nrw = 0;
        apply_reset();
        prog[10'h010] = '{jump:0, branch:0, rw:1, mr:0, mw:0, done:0, imm:8'h00};
        prog[10'h011] = '{jump:0, branch:0, rw:1, mr:0, mw:0, done:0, imm:8'h00};
        prog[10'h012] = '{jump:0, branch:0, rw:1, mr:0, mw:0, done:0, imm:8'h00};
        prog[10'h013] = '{jump:0, branch:0, rw:0, mr:0, mw:0, done:1, imm:8'h00};
        bus.imem_valid = 1'b1;
        do_start(10'h010);
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req === 1'b1) begin
                if (nf < 4) fa[nf] = bus.imem_addr;
                nf++;
            end
            if (bus.reg_we === 1'b1) nrw++;
            n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL prog_halted_early: cycle %0d halted=%b want 0", i, halted); end
            step();
        end
        n_cmp++; if (nf !== 4) begin n_fail++; $display("FAIL prog_fetch_count: got %0d want 4", nf); end
        n_cmp++; if (fa[0] !== 10'h010 || fa[1] !== 10'h011 || fa[2] !== 10'h012 || fa[3] !== 10'h013)
            begin n_fail++; $display("FAIL prog_fetch_addrs: got %h %h %h %h want 010 011 012 013", fa[0], fa[1], fa[2], fa[3]); end
        n_cmp++; if (nrw !== 3) begin n_fail++; $display("FAIL prog_reg_we_pulses: got %0d want 3", nrw); end
        n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL prog_halted: halted=%b busy=%b want 1/0", halted, busy); end
        n_cmp++; if (instr_count !== 16'd4) begin n_fail++; $display("FAIL prog_count: got %0d want 4", instr_count); end
        n_cmp++; if (bus.imem_addr !== 10'h013) begin n_fail++; $display("FAIL prog_halt_pc: got %h want 013", bus.imem_addr); end
        // restart from HALT: halted drops, count clears
        bus.imem_valid = 1'b0;
        do_start(10'h070);
        n_cmp++; if (halted !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_status: halted=%b busy=%b want 0/1", halted, busy); end
        n_cmp++; if (bus.imem_addr !== 10'h070 || instr_count !== 16'd0)
            begin n_fail++; $display("FAIL restart_pc_count: addr=%h count=%0d want 070/0", bus.imem_addr, instr_count); end
    endtask

    task automatic test_jump();
        apply_reset();
        prog[10'h020] = '{jump:1, branch:0, rw:0, mr:0, mw:0, done:0, imm:8'hFC};
        bus.imem_valid = 1'b1;
        do_start(10'h020);
        step();
        step();
        n_cmp++; if (bus.imem_addr !== 10'h01C) begin n_fail++; $display("FAIL jump_back: got %h want 01c", bus.imem_addr); end
        n_cmp++; if (instr_count !== 16'd1) begin n_fail++; $display("FAIL jump_count: got %0d want 1", instr_count); end

        apply_reset();
        prog[10'h3FF] = '{jump:1, branch:0, rw:0, mr:0, mw:0, done:0, imm:8'h01};
        bus.imem_valid = 1'b1;
        do_start(10'h3FF);
        step();
        step();
        n_cmp++; if (bus.imem_addr !== 10'h000) begin n_fail++; $display("FAIL jump_wrap_fwd: got %h want 000", bus.imem_addr); end

        apply_reset();
        prog[10'h000] = '{jump:1, branch:0, rw:0, mr:0, mw:0, done:0, imm:8'hFF};
        bus.imem_valid = 1'b1;
        do_start(10'h000);
        step();
        step();
        n_cmp++; if (bus.imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL jump_wrap_back: got %h want 3ff", bus.imem_addr); end
    endtask

    task automatic test_branch();
        apply_reset();
        prog[10'h005] = '{jump:0, branch:1, rw:0, mr:0, mw:0, done:0, imm:8'h00};
        bus.imem_valid = 1'b1;
        bus.alu_zero   = 1'b1;
        do_start(10'h005);
        step();
        step();
        n_cmp++; if (bus.imem_addr !== 10'h007) begin n_fail++; $display("FAIL beq_taken: got %h want 007", bus.imem_addr); end

        apply_reset();
        prog[10'h005] = '{jump:0, branch:1, rw:0, mr:0, mw:0, done:0, imm:8'h00};
        bus.imem_valid = 1'b1;
        bus.alu_zero   = 1'b0;
        do_start(10'h005);
        step();
        step();
        n_cmp++; if (bus.imem_addr !== 10'h006) begin n_fail++; $display("FAIL beq_not_taken: got %h want 006", bus.imem_addr); end

        apply_reset();
        prog[10'h005] = '{jump:1, branch:1, rw:0, mr:0, mw:0, done:0, imm:8'h03};
        bus.imem_valid = 1'b1;
        bus.alu_zero   = 1'b1;
        do_start(10'h005);
        step();
        step();
        n_cmp++; if (bus.imem_addr !== 10'h008) begin n_fail++; $display("FAIL jump_over_beq: got %h want 008", bus.imem_addr); end
    endtask

    task automatic test_load();
        int nreq;
        int nrw;
        logic rw_at_ack;
        nreq      = 0;
        nrw       = 0;
        rw_at_ack = 1'b0;
        apply_reset();
        prog[10'h030] = '{jump:0, branch:0, rw:0, mr:1, mw:0, done:0, imm:8'h00};
        bus.imem_valid = 1'b1;
        do_start(10'h030);
        step();
        n_cmp++; if (bus.reg_we !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL load_exec: reg_we=%b mem_req=%b want 0/0", bus.reg_we, bus.mem_req); end
        step();
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = (i == 3);
            #1;
            if (bus.mem_req === 1'b1) nreq++;
            if (bus.reg_we === 1'b1) nrw++;
            if (i == 3) rw_at_ack = bus.reg_we;
            n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL load_mem_we: cycle %0d got %b want 0", i, bus.mem_we); end
            step();
        end
        bus.mem_ack = 1'b0;
        n_cmp++; if (nreq !== 4) begin n_fail++; $display("FAIL load_req_cycles: got %0d want 4", nreq); end
        n_cmp++; if (nrw !== 1 || rw_at_ack !== 1'b1) begin n_fail++; $display("FAIL load_reg_we: pulses=%0d at_ack=%b want 1/1", nrw, rw_at_ack); end
        n_cmp++; if (bus.imem_addr !== 10'h031 || bus.imem_req !== 1'b1 || bus.mem_req !== 1'b0)
            begin n_fail++; $display("FAIL load_next_fetch: addr=%h imem_req=%b mem_req=%b want 031/1/0", bus.imem_addr, bus.imem_req, bus.mem_req); end
        n_cmp++; if (instr_count !== 16'd1) begin n_fail++; $display("FAIL load_count: got %0d want 1", instr_count); end
    endtask

    task automatic test_store();
        int nrw;
        nrw = 0;
        apply_reset();
        prog[10'h040] = '{jump:0, branch:0, rw:1, mr:0, mw:1, done:0, imm:8'h00};
        bus.imem_valid = 1'b1;
        do_start(10'h040);
        if (bus.reg_we === 1'b1) nrw++;
        step();
        if (bus.reg_we === 1'b1) nrw++;
        step();
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL store_mem: req=%b we=%b want 1/1", bus.mem_req, bus.mem_we); end
        bus.mem_ack = 1'b1;
        #1;
        if (bus.reg_we === 1'b1) nrw++;
        step();
        bus.mem_ack = 1'b0;
        if (bus.reg_we === 1'b1) nrw++;
        n_cmp++; if (nrw !== 0) begin n_fail++; $display("FAIL store_reg_we: pulses=%0d want 0", nrw); end
        n_cmp++; if (bus.imem_addr !== 10'h041 || instr_count !== 16'd1)
            begin n_fail++; $display("FAIL store_advance: addr=%h count=%0d want 041/1", bus.imem_addr, instr_count); end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        prog[10'h050] = '{jump:0, branch:0, rw:1, mr:0, mw:0, done:0, imm:8'h00};
        prog[10'h051] = '{jump:0, branch:0, rw:1, mr:1, mw:0, done:0, imm:8'h00};
        bus.imem_valid = 1'b1;
        do_start(10'h050);
        step();
        step();
        step();
        step();
        n_cmp++; if (bus.mem_req !== 1'b1 || instr_count !== 16'd1)
            begin n_fail++; $display("FAIL abort_setup: mem_req=%b count=%0d want 1/1", bus.mem_req, instr_count); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_async: mem_req=%b busy=%b want 0/0", bus.mem_req, busy); end
        n_cmp++; if (bus.imem_addr !== 10'h000 || instr_count !== 16'd0)
            begin n_fail++; $display("FAIL abort_state: addr=%h count=%0d want 000/0", bus.imem_addr, instr_count); end
        step();
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        n_cmp++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL abort_late_ack_we: got %b want 0", bus.reg_we); end
        step();
        bus.mem_ack = 1'b0;
        n_cmp++; if (busy !== 1'b0 || bus.imem_req !== 1'b0 || instr_count !== 16'd0 || bus.imem_addr !== 10'h000)
            begin n_fail++; $display("FAIL abort_late_ack: busy=%b imem_req=%b count=%0d addr=%h want 0/0/0/000", busy, bus.imem_req, instr_count, bus.imem_addr); end
    endtask

    task automatic test_fetch_stall();
        apply_reset();
        bus.imem_valid = 1'b0;
        do_start(10'h060);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start_pc = 10'h123;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h060 || bus.ir_load !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold: cycle %0d req=%b addr=%h ir_load=%b want 1/060/0", i, bus.imem_req, bus.imem_addr, bus.ir_load); end
            step();
        end
        start = 1'b0;
        n_cmp++; if (instr_count !== 16'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_status: count=%0d busy=%b want 0/1", instr_count, busy); end
        // start coincident with imem_valid in FETCH: fetch proceeds, start ignored
        start_pc       = 10'h200;
        start          = 1'b1;
        bus.imem_valid = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0 || busy !== 1'b1 || bus.imem_addr !== 10'h060)
            begin n_fail++; $display("FAIL start_with_valid: req=%b busy=%b addr=%h want 0/1/060", bus.imem_req, busy, bus.imem_addr); end
        step();
        n_cmp++; if (bus.imem_addr !== 10'h061 || instr_count !== 16'd1)
            begin n_fail++; $display("FAIL start_with_valid_next: addr=%h count=%0d want 061/1", bus.imem_addr, instr_count); end
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        ir             = '0;
        rst_n          = 1'b0;
        start          = 1'b0;
        start_pc       = '0;
        bus.imem_valid = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.alu_zero   = 1'b0;
        test_reset();
        test_program();
        test_jump();
        test_branch();
        test_load();
        test_store();
        test_reset_mid_mem();
        test_fetch_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the 9-bit-instruction datapath.
- Fetches from instruction memory, latches the instruction register, and lets the combinational decoder settle for one execute cycle.
- Sequences data-memory handshakes, qualifies register-file writes, and computes the next PC for jump and BEQ.
- Sits between instruction memory, decoder/ALU, data memory and the top-level start/done interface.

Parameters:
- PC_WIDTH, 10, program counter and instruction address width.
- IMM_WIDTH, 8, width of the decoder immediate, used as a signed jump offset.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution at start_pc; honoured only in IDLE or HALT.
- start_pc  in  PC_WIDTH  initial PC.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address; always equals the PC register.
- imem_valid  in  1  fetched instruction is present on the IR input this cycle.
- ir_load  out  1  instruction register load strobe.
- dec_jump  in  1  decoder: relative jump.
- dec_branch  in  1  decoder: BEQ.
- alu_zero  in  1  ALU equality result for BEQ.
- dec_imm  in  IMM_WIDTH  decoder immediate, two's complement.
- dec_reg_write  in  1  decoder register-write request.
- dec_mem_read  in  1  decoder: load.
- dec_mem_write  in  1  decoder: store.
- dec_done  in  1  decoder: halt instruction.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write enable.
- mem_ack  in  1  data memory completion.
- reg_we  out  1  qualified register-file write enable.
- busy  out  1  program running.
- halted  out  1  halt instruction retired.
- instr_count  out  CNT_WIDTH  retired instructions since last start.

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALT.
- Reset (async, rst_n=0): state=IDLE, pc=0, instr_count=0. Every output is 0 except imem_addr, which shows pc=0. Reset mid-operation aborts any fetch or memory access immediately; no completion is issued.
- Output decode:
  - Moore (from state only): imem_req=(FETCH), mem_req=(MEM), busy=(FETCH|EXEC|MEM), halted=(HALT).
  - mem_we = (MEM & dec_mem_write). The IR is stable, so this is effectively Moore.
  - ir_load and reg_we are combinational single-cycle pulses.
- IDLE / HALT:
  - start=1 -> pc<=start_pc, instr_count<=0, next FETCH.
  - halted drops the cycle after start is accepted.
- FETCH:
  - imem_req=1, held until imem_valid.
  - imem_valid=1 -> ir_load=1, next EXEC.
  - Unbounded wait is legal.
- EXEC (exactly one cycle; decoder outputs valid); priority order:
  1. dec_done: next HALT, instr_count+1, pc unchanged, reg_we=0.
  2. dec_mem_read|dec_mem_write: next MEM, pc unchanged, reg_we=0.
  3. Otherwise: reg_we=dec_reg_write, instr_count+1, pc<=next_pc, next FETCH.
- next_pc rules:
  - dec_jump -> pc + sign-extended dec_imm.
  - else dec_branch & alu_zero -> pc+2 (skip next instruction).
  - else pc+1.
  - Jump wins if jump and branch are both asserted.
  - All PC arithmetic is modulo 2^PC_WIDTH (wraps, e.g. 1023+1=0; 0 + imm 0xFF = 1023).
- MEM:
  - mem_req=1, held stable until mem_ack.
  - mem_ack=1 -> reg_we=dec_mem_read, pc<=pc+1, instr_count+1, next FETCH.
  - Store never writes the register file even if dec_reg_write=1.
- Latency: non-memory instruction = 1 fetch cycle (imem_valid same cycle) + 1 EXEC = 2 cycles; memory instruction = 3 cycles minimum.
- Ignored inputs:
  - imem_valid outside FETCH; mem_ack outside MEM.
  - start while busy (no effect on pc, count or state).
  - start and imem_valid together in FETCH: start ignored.
- instr_count wraps at 2^CNT_WIDTH.

Test Plan:
- Reset release, then start=1 with start_pc=0x010; imem_valid always 1; program of three ADDs then done:
  - imem_addr sequence 0x010, 0x011, 0x012, 0x013.
  - reg_we pulses 3 times; halted=1 at cycle 8; instr_count=4.
- Jump at pc=0x020 with dec_imm=0xFC (-4) -> next imem_addr=0x01C. Jump at pc=0x3FF with imm=0x01 -> 0x000 (wrap).
- BEQ at pc=0x005:
  - alu_zero=1 -> next fetch 0x007.
  - alu_zero=0 -> next fetch 0x006.
  - dec_jump and dec_branch both asserted with imm=3 -> 0x008.
- Load with mem_ack delayed 3 cycles:
  - mem_req held 4 cycles; reg_we one pulse coincident with mem_ack; pc advances by 1.
  - Store: mem_we=1, reg_we never asserts.
- rst_n low mid-MEM for 1 cycle -> mem_req=0 asynchronously, state IDLE, pc=0, instr_count=0; a later mem_ack is ignored.
- start asserted during FETCH -> ignored. imem_valid held 0 for 10 cycles -> imem_req stays 1 and imem_addr is stable.
